// File: rtl/usart_pkg.sv
// Shared USART definitions: receiver/transmitter FSM states, frame-format
// limits and defaults, and the baud divisor helper.
package usart_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } usart_state_e;

   localparam int USART_DEF_CLK_FREQ      = 100000000;
   localparam int USART_DEF_BAUD_RATE     = 115200;
   localparam int USART_DEF_DATA_BITS     = 8;
   localparam int USART_DEF_STOP_BITS     = 1;

   localparam int USART_MIN_DATA_BITS     = 5;
   localparam int USART_MAX_DATA_BITS     = 9;
   localparam int USART_MIN_STOP_BITS     = 1;
   localparam int USART_MAX_STOP_BITS     = 2;
   localparam int USART_MIN_CLKS_PER_BIT  = 4;

   // Integer divide; the remainder shows up as a small per-frame baud error.
   function automatic int clks_per_bit(input int clk_freq, input int baud_rate);
      return clk_freq / baud_rate;
   endfunction

endpackage

// File: rtl/usart_sync2.sv
// Two-flop synchroniser for asynchronous inputs; reset value is chosen per use
// so an idle-high line does not look like an edge when reset releases.
module usart_sync2 #(
   parameter int               WIDTH     = 1,
   parameter logic [WIDTH-1:0] RESET_VAL = '1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] meta_q;
   logic [WIDTH-1:0] meta_d;
   logic [WIDTH-1:0] sync_q;
   logic [WIDTH-1:0] sync_d;

   always_comb begin
      meta_d = d;
      sync_d = meta_q;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         meta_q <= RESET_VAL;
         sync_q <= RESET_VAL;
      end else begin
         meta_q <= meta_d;
         sync_q <= sync_d;
      end
   end

   assign q = sync_q;

endmodule

// File: rtl/usart_rx.sv
// USART receiver: mid-bit sampling of a resynchronised line, valid/ready
// holding register for the received word, framing-error and overrun pulses.
module usart_rx
   import usart_pkg::*;
#(
   parameter int CLK_FREQ  = USART_DEF_CLK_FREQ,
   parameter int BAUD_RATE = USART_DEF_BAUD_RATE,
   parameter int DATA_BITS = USART_DEF_DATA_BITS,
   parameter int STOP_BITS = USART_DEF_STOP_BITS
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 rx,
   output logic [DATA_BITS-1:0] data,
   output logic                 valid,
   input  logic                 ready,
   output logic                 busy,
   output logic                 frame_err,
   output logic                 overrun
);

   localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD_RATE);
   localparam int HALF         = CLKS_PER_BIT / 2;
   localparam int CNT_W        = $clog2(CLKS_PER_BIT);
   localparam int BIT_W        = $clog2(DATA_BITS);

   localparam logic [CNT_W-1:0] CNT_HALF  = CNT_W'(HALF - 1);
   localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(DATA_BITS - 1);
   localparam logic             STOP_LAST = 1'(STOP_BITS - 1);

   if (CLKS_PER_BIT < USART_MIN_CLKS_PER_BIT) begin : g_chk_cpb
      $error("usart_rx: CLK_FREQ/BAUD_RATE must be at least 4");
   end
   if (DATA_BITS < USART_MIN_DATA_BITS || DATA_BITS > USART_MAX_DATA_BITS) begin : g_chk_data
      $error("usart_rx: DATA_BITS out of range 5..9");
   end
   if (STOP_BITS < USART_MIN_STOP_BITS || STOP_BITS > USART_MAX_STOP_BITS) begin : g_chk_stop
      $error("usart_rx: STOP_BITS out of range 1..2");
   end

   logic rx_s;

   usart_sync2 #(
      .WIDTH     (1),
      .RESET_VAL (1'b1)
   ) u_sync (
      .clk   (clk),
      .reset (reset),
      .d     (rx),
      .q     (rx_s)
   );

   usart_state_e state_q, state_d;

   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [BIT_W-1:0]     bit_idx_q, bit_idx_d;
   logic                 stop_idx_q, stop_idx_d;
   logic [DATA_BITS-1:0] shreg_q, shreg_d;
   logic                 bad_q, bad_d;
   logic                 done_q, done_d;
   logic                 done_bad_q, done_bad_d;
   logic [DATA_BITS-1:0] data_q, data_d;
   logic                 valid_q, valid_d;
   logic                 frame_err_q, frame_err_d;
   logic                 overrun_q, overrun_d;

   logic cnt_at_half;
   logic cnt_at_last;

   assign cnt_at_half = (cnt_q == CNT_HALF);
   assign cnt_at_last = (cnt_q == CNT_LAST);

   // State register
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: begin
            if (!rx_s) state_d = START;
         end
         START: begin
            if (cnt_at_half) state_d = rx_s ? IDLE : DATA;
         end
         DATA: begin
            if (cnt_at_last && bit_idx_q == BIT_LAST) state_d = STOP;
         end
         STOP: begin
            if (cnt_at_last && stop_idx_q == STOP_LAST) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Bit timing, sampling and frame completion
   always_comb begin
      cnt_d      = cnt_q;
      bit_idx_d  = bit_idx_q;
      stop_idx_d = stop_idx_q;
      shreg_d    = shreg_q;
      bad_d      = bad_q;
      done_d     = 1'b0;
      done_bad_d = 1'b0;
      unique case (state_q)
         IDLE: begin
            cnt_d      = '0;
            bit_idx_d  = '0;
            stop_idx_d = 1'b0;
            bad_d      = 1'b0;
         end
         START: begin
            cnt_d = cnt_at_half ? '0 : cnt_q + 1'b1;
         end
         DATA: begin
            if (cnt_at_last) begin
               cnt_d     = '0;
               shreg_d   = {rx_s, shreg_q[DATA_BITS-1:1]};
               bit_idx_d = bit_idx_q + 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         STOP: begin
            if (cnt_at_last) begin
               cnt_d      = '0;
               stop_idx_d = stop_idx_q + 1'b1;
               if (stop_idx_q == STOP_LAST) begin
                  done_d     = 1'b1;
                  done_bad_d = bad_q | ~rx_s;
               end else begin
                  bad_d = bad_q | ~rx_s;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: cnt_d = '0;
      endcase
   end

   // Output logic; a load in the same cycle as a handshake keeps valid set
   always_comb begin
      busy        = (state_q != IDLE);
      data_d      = data_q;
      valid_d     = valid_q;
      frame_err_d = 1'b0;
      overrun_d   = 1'b0;
      if (valid_q && ready) valid_d = 1'b0;
      if (done_q) begin
         if (done_bad_q) begin
            frame_err_d = 1'b1;
         end else if (!valid_q || ready) begin
            data_d  = shreg_q;
            valid_d = 1'b1;
         end else begin
            overrun_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q       <= '0;
         bit_idx_q   <= '0;
         stop_idx_q  <= 1'b0;
         shreg_q     <= '0;
         bad_q       <= 1'b0;
         done_q      <= 1'b0;
         done_bad_q  <= 1'b0;
         data_q      <= '0;
         valid_q     <= 1'b0;
         frame_err_q <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         cnt_q       <= cnt_d;
         bit_idx_q   <= bit_idx_d;
         stop_idx_q  <= stop_idx_d;
         shreg_q     <= shreg_d;
         bad_q       <= bad_d;
         done_q      <= done_d;
         done_bad_q  <= done_bad_d;
         data_q      <= data_d;
         valid_q     <= valid_d;
         frame_err_q <= frame_err_d;
         overrun_q   <= overrun_d;
      end
   end

   assign data      = data_q;
   assign valid     = valid_q;
   assign frame_err = frame_err_q;
   assign overrun   = overrun_q;

endmodule

// File: tb/tb_usart_rx.sv
// Bench for usart_rx: a slow 16-clk/bit instance for timing-exact scenarios and
// a 100 MHz / 115200 instance (7 data, 2 stop bits) fed by a behavioural transmitter.
module tb_usart_rx;

   localparam int CPB_SLOW = 16;
   localparam int CPB_FAST = 100000000 / 115200;

   logic       clk = 1'b0;
   logic       reset;
   logic       rx, rx2;
   logic       ready, ready2;
   logic [7:0] data;
   logic [6:0] data2;
   logic       valid, valid2;
   logic       busy, busy2;
   logic       frame_err, frame_err2;
   logic       overrun, overrun2;

   int total = 0;
   int bad   = 0;

   logic [8:0] exp_q[$];
   logic [8:0] got_q[$];
   logic [8:0] exp2_q[$];
   logic [8:0] got2_q[$];
   int ferr_cnt = 0, ovr_cnt = 0, ferr2_cnt = 0, ovr2_cnt = 0;

   always #5 clk = ~clk;

   usart_rx #(
      .CLK_FREQ  (16),
      .BAUD_RATE (1),
      .DATA_BITS (8),
      .STOP_BITS (1)
   ) u_dut (
      .clk       (clk),
      .reset     (reset),
      .rx        (rx),
      .data      (data),
      .valid     (valid),
      .ready     (ready),
      .busy      (busy),
      .frame_err (frame_err),
      .overrun   (overrun)
   );

   usart_rx #(
      .CLK_FREQ  (100000000),
      .BAUD_RATE (115200),
      .DATA_BITS (7),
      .STOP_BITS (2)
   ) u_fast (
      .clk       (clk),
      .reset     (reset),
      .rx        (rx2),
      .data      (data2),
      .valid     (valid2),
      .ready     (ready2),
      .busy      (busy2),
      .frame_err (frame_err2),
      .overrun   (overrun2)
   );

   // Output monitor: capture handshaken words and count error pulses
   always @(negedge clk) begin
      if (valid && ready)   got_q.push_back({1'b0, data});
      if (frame_err)        ferr_cnt++;
      if (overrun)          ovr_cnt++;
      if (valid2 && ready2) got2_q.push_back({2'b00, data2});
      if (frame_err2)       ferr2_cnt++;
      if (overrun2)         ovr2_cnt++;
   end

   task automatic drive(input bit fast, input logic v);
      if (fast) rx2 = v;
      else      rx  = v;
   endtask

   // Caller must be at a negedge; consecutive calls give back-to-back frames
   task automatic send_frame(input bit fast, input logic [8:0] word, input int nbits,
                             input int nstop, input int cpb, input logic stop_val);
      drive(fast, 1'b0);
      repeat (cpb) @(negedge clk);
      for (int i = 0; i < nbits; i++) begin
         drive(fast, word[i]);
         repeat (cpb) @(negedge clk);
      end
      for (int i = 0; i < nstop; i++) begin
         drive(fast, stop_val);
         repeat (cpb) @(negedge clk);
      end
      drive(fast, 1'b1);
   endtask

   task automatic test_reset();
      reset = 1'b1; rx = 1'b1; rx2 = 1'b1; ready = 1'b1; ready2 = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      total++; if (data !== 8'h00)     begin bad++; $display("FAIL reset_data got=%h want=00", data); end
      total++; if (valid !== 1'b0)     begin bad++; $display("FAIL reset_valid got=%b want=0", valid); end
      total++; if (busy !== 1'b0)      begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
      total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL reset_ferr got=%b want=0", frame_err); end
      total++; if (overrun !== 1'b0)   begin bad++; $display("FAIL reset_ovr got=%b want=0", overrun); end
      reset = 1'b0;
      repeat (4) @(posedge clk);
      $display("test_reset: outputs checked under reset");
   endtask

   task automatic test_basic_frame();
      int cyc;
      int f0, o0;
      logic seen;
      logic [7:0] dseen;
      logic [8:0] e, g;
      logic vafter;
      f0 = ferr_cnt; o0 = ovr_cnt;
      cyc = 0; seen = 1'b0; dseen = '0; vafter = 1'bx;
      @(negedge clk);
      exp_q.push_back(9'h0A5);
      fork
         send_frame(1'b0, 9'h0A5, 8, 1, CPB_SLOW, 1'b1);
         begin
            while (!seen && cyc < 400) begin
               @(posedge clk); cyc++;
               @(negedge clk);
               if (valid) begin seen = 1'b1; dseen = data; end
            end
            @(negedge clk);
            vafter = valid;
         end
      join
      repeat (20) @(negedge clk);
      @(posedge clk); #1;
      // start edge -> 2 sync + 8 start + 8*16 data + 16 to mid-stop + 2 output
      total++; if (cyc != 156)       begin bad++; $display("FAIL t1_latency got=%0d want=156", cyc); end
      total++; if (dseen !== 8'hA5)  begin bad++; $display("FAIL t1_data got=%h want=a5", dseen); end
      total++; if (vafter !== 1'b0)  begin bad++; $display("FAIL t1_valid_width got=%b want=0", vafter); end
      total++; if (ferr_cnt != f0 || ovr_cnt != o0)
         begin bad++; $display("FAIL t1_no_err got ferr=%0d ovr=%0d want ferr=%0d ovr=%0d", ferr_cnt, ovr_cnt, f0, o0); end
      e = exp_q.pop_front();
      total++;
      if (got_q.size() == 0) begin bad++; $display("FAIL t1_sb got=none want=%h", e); end
      else begin
         g = got_q.pop_front();
         if (g !== e) begin bad++; $display("FAIL t1_sb got=%h want=%h", g, e); end
      end
      $display("test_basic_frame: word a5 latency=%0d", cyc);
   endtask

   task automatic test_glitch();
      int bcnt;
      int f0;
      logic vseen;
      f0 = ferr_cnt; bcnt = 0; vseen = 1'b0;
      @(negedge clk);
      rx = 1'b0;
      for (int i = 0; i < 44; i++) begin
         if (i == 4) rx = 1'b1;
         @(negedge clk);
         if (busy)  bcnt++;
         if (valid) vseen = 1'b1;
      end
      @(posedge clk); #1;
      total++; if (bcnt < 1 || bcnt > 12) begin bad++; $display("FAIL t2_busy_len got=%0d want=1..12", bcnt); end
      total++; if (vseen !== 1'b0)        begin bad++; $display("FAIL t2_valid got=%b want=0", vseen); end
      total++; if (ferr_cnt != f0)        begin bad++; $display("FAIL t2_ferr got=%0d want=%0d", ferr_cnt, f0); end
      total++; if (got_q.size() != 0)     begin bad++; $display("FAIL t2_words got=%0d want=0", got_q.size()); end
      $display("test_glitch: busy for %0d clk", bcnt);
   endtask

   task automatic test_frame_error();
      int f0, o0;
      f0 = ferr_cnt; o0 = ovr_cnt;
      @(negedge clk);
      send_frame(1'b0, 9'h03C, 8, 1, CPB_SLOW, 1'b0);
      repeat (40) @(negedge clk);
      @(posedge clk); #1;
      total++; if (ferr_cnt != f0 + 1) begin bad++; $display("FAIL t3_ferr_pulse got=%0d want=%0d", ferr_cnt, f0 + 1); end
      total++; if (valid !== 1'b0)     begin bad++; $display("FAIL t3_valid got=%b want=0", valid); end
      total++; if (data !== 8'hA5)     begin bad++; $display("FAIL t3_data got=%h want=a5", data); end
      total++; if (ovr_cnt != o0 || got_q.size() != 0)
         begin bad++; $display("FAIL t3_side got ovr=%0d words=%0d want ovr=%0d words=0", ovr_cnt, got_q.size(), o0); end
      $display("test_frame_error: frame 3c with bad stop");
   endtask

   task automatic test_overrun();
      int f0, o0;
      logic [8:0] e, g;
      f0 = ferr_cnt; o0 = ovr_cnt;
      @(posedge clk); #1 ready = 1'b0;
      @(negedge clk);
      exp_q.push_back(9'h011);
      send_frame(1'b0, 9'h011, 8, 1, CPB_SLOW, 1'b1);
      send_frame(1'b0, 9'h022, 8, 1, CPB_SLOW, 1'b1);
      repeat (40) @(negedge clk);
      @(posedge clk); #1;
      total++; if (valid !== 1'b1)      begin bad++; $display("FAIL t4_valid_held got=%b want=1", valid); end
      total++; if (data !== 8'h11)      begin bad++; $display("FAIL t4_data_kept got=%h want=11", data); end
      total++; if (ovr_cnt != o0 + 1)   begin bad++; $display("FAIL t4_ovr_pulse got=%0d want=%0d", ovr_cnt, o0 + 1); end
      total++; if (ferr_cnt != f0)      begin bad++; $display("FAIL t4_ferr got=%0d want=%0d", ferr_cnt, f0); end
      ready = 1'b1;
      @(posedge clk); #1;
      total++; if (valid !== 1'b0)      begin bad++; $display("FAIL t4_valid_drop got=%b want=0", valid); end
      total++; if (data !== 8'h11)      begin bad++; $display("FAIL t4_data_after got=%h want=11", data); end
      e = exp_q.pop_front();
      total++;
      if (got_q.size() != 1) begin bad++; $display("FAIL t4_sb got_words=%0d want=1 (%h)", got_q.size(), e); end
      else begin
         g = got_q.pop_front();
         if (g !== e) begin bad++; $display("FAIL t4_sb got=%h want=%h", g, e); end
      end
      got_q.delete();
      $display("test_overrun: 11 kept, 22 dropped");
   endtask

   task automatic test_reset_mid_frame();
      int f0, o0;
      logic [8:0] e, g;
      logic [7:0] d_r;
      logic v_r, b_r, fe_r, ov_r;
      f0 = ferr_cnt; o0 = ovr_cnt;
      @(negedge clk);
      fork
         send_frame(1'b0, 9'h0FF, 8, 1, CPB_SLOW, 1'b1);
         begin
            repeat (4 * CPB_SLOW + CPB_SLOW / 2) @(negedge clk);
            @(posedge clk); #1 reset = 1'b1;
            @(posedge clk); #1 reset = 1'b0;
            d_r = data; v_r = valid; b_r = busy; fe_r = frame_err; ov_r = overrun;
         end
      join
      total++; if (d_r !== 8'h00) begin bad++; $display("FAIL t5_data got=%h want=00", d_r); end
      total++; if (v_r !== 1'b0 || fe_r !== 1'b0 || ov_r !== 1'b0)
         begin bad++; $display("FAIL t5_flags got v=%b fe=%b ov=%b want 0 0 0", v_r, fe_r, ov_r); end
      total++; if (b_r !== 1'b0)  begin bad++; $display("FAIL t5_busy got=%b want=0", b_r); end
      repeat (40) @(negedge clk);
      @(posedge clk); #1;
      total++; if (ferr_cnt != f0 || ovr_cnt != o0 || got_q.size() != 0)
         begin bad++; $display("FAIL t5_no_pulse got ferr=%0d ovr=%0d words=%0d want %0d %0d 0", ferr_cnt, ovr_cnt, got_q.size(), f0, o0); end
      @(negedge clk);
      exp_q.push_back(9'h05A);
      send_frame(1'b0, 9'h05A, 8, 1, CPB_SLOW, 1'b1);
      repeat (40) @(negedge clk);
      @(posedge clk); #1;
      e = exp_q.pop_front();
      total++;
      if (got_q.size() == 0) begin bad++; $display("FAIL t5_sb got=none want=%h", e); end
      else begin
         g = got_q.pop_front();
         if (g !== e) begin bad++; $display("FAIL t5_sb got=%h want=%h", g, e); end
      end
      $display("test_reset_mid_frame: ff abandoned, 5a received");
   endtask

   task automatic test_back_to_back();
      logic [8:0] words[3];
      logic [8:0] e, g;
      words[0] = 9'h000; words[1] = 9'h07F; words[2] = 9'h055;
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         exp2_q.push_back(words[i]);
         send_frame(1'b1, words[i], 7, 2, CPB_FAST, 1'b1);
      end
      repeat (2000) @(negedge clk);
      @(posedge clk); #1;
      for (int i = 0; i < 3; i++) begin
         e = exp2_q.pop_front();
         total++;
         if (got2_q.size() == 0) begin bad++; $display("FAIL t6_word%0d got=none want=%h", i, e); end
         else begin
            g = got2_q.pop_front();
            if (g !== e) begin bad++; $display("FAIL t6_word%0d got=%h want=%h", i, g, e); end
         end
      end
      total++; if (got2_q.size() != 0) begin bad++; $display("FAIL t6_extra got=%0d want=0", got2_q.size()); end
      total++; if (ferr2_cnt != 0 || ovr2_cnt != 0)
         begin bad++; $display("FAIL t6_errs got ferr=%0d ovr=%0d want 0 0", ferr2_cnt, ovr2_cnt); end
      $display("test_back_to_back: 00 7f 55 at 115200 7N2");
   endtask

   initial begin
      test_reset();
      test_basic_frame();
      test_glitch();
      test_frame_error();
      test_overrun();
      test_reset_mid_frame();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
